// File: rtl/shifter_pkg.sv
// Shared types and constants for the sequential left shifter.
//   N          data width (fixed at 32)
//   L          number of binary-weighted shift stages, also the shamt width
//   KW         width of the stage counter that walks 0..L-1
//   shift_state_t  controller states
//   shamt_t    shift amount type
//   stage_t    stage counter type
package shifter_pkg;

    localparam int N  = 32;
    localparam int L  = $clog2(N);
    localparam int KW = $clog2(L);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } shift_state_t;

    typedef logic [L-1:0]  shamt_t;
    typedef logic [KW-1:0] stage_t;
    typedef logic [N-1:0]  data_t;

endpackage : shifter_pkg

// File: rtl/shift_left_stage.sv
// One conditional power-of-two left shift, selected by stage index.
// A single instance serves every stage; the caller steps k once per clock.
// Ports:
//   data    value to shift
//   en      apply the shift for this stage when 1, pass through when 0
//   k       stage index; stage k shifts by 1 << k
//   result  data << (1 << k) when en=1, else data; vacated LSBs are zero
module shift_left_stage
    import shifter_pkg::*;
(
    input  data_t  data,
    input  logic   en,
    input  stage_t k,
    output data_t  result
);

    // Each arm is a constant shift, so this is a 5:1 mux of fixed wirings
    // rather than a barrel shifter.
    always_comb begin
        // NOTE: assign a default before any branch so every path drives
        // result; a missed path would otherwise infer a latch.
        result = data;
        if (en) begin
            case (k)
                stage_t'(0): result = data << 1;
                stage_t'(1): result = data << 2;
                stage_t'(2): result = data << 4;
                stage_t'(3): result = data << 8;
                stage_t'(4): result = data << 16;
                default:     result = data;
            endcase
        end
    end

endmodule : shift_left_stage

// File: rtl/shift_left_sequential.sv
// Multi-cycle logical left shifter with valid/ready handshakes.
// An accepted operand is shifted by one binary-weighted stage per clock for
// exactly L clocks, then held in S_DONE until the consumer takes it.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operand present
//   in_ready   block can accept an operand (high only in S_IDLE)
//   in         value to shift
//   shamt      left-shift amount, 0..N-1
//   out_valid  result present (high only in S_DONE)
//   out_ready  consumer accepts result
//   out        shifted result, driven straight from the accumulator register
module shift_left_sequential
    import shifter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  data_t  in,
    input  shamt_t shamt,
    output logic   out_valid,
    input  logic   out_ready,
    output data_t  out
);

    shift_state_t state, state_next;
    data_t        acc;
    data_t        stage_out;
    shamt_t       amt;
    stage_t       k;
    logic         last_stage;

    assign last_stage = (k == stage_t'(L - 1));

    shift_left_stage u_stage (
        .data   (acc),
        .en     (amt[k]),
        .k      (k),
        .result (stage_out)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of process order.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid)   state_next = S_SHIFT;
            S_SHIFT: if (last_stage) state_next = S_DONE;
            S_DONE:  if (out_ready)  state_next = S_IDLE;
            default:                 state_next = S_IDLE;
        endcase
    end

    // Output logic: handshake flags depend on state only.
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Datapath: accumulator, captured amount and stage counter. Outside
    // S_IDLE the input side is ignored, so a late in_valid cannot disturb
    // an operation in flight or a result awaiting out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: plain registers (not memories), so every one is cleared
            // by reset; an interrupted result must not leak out afterwards.
            acc <= '0;
            amt <= '0;
            k   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        acc <= in;
                        amt <= shamt;
                        k   <= '0;
                    end
                end
                S_SHIFT: begin
                    acc <= stage_out;
                    k   <= k + stage_t'(1);
                end
                default: ;
            endcase
        end
    end

    assign out = acc;

endmodule : shift_left_sequential

// File: tb/tb_shift_left_sequential.sv
// Directed bench for shift_left_sequential: a table of single operations
// followed by hand-written sequences for backpressure, back-to-back
// operation and reset in mid-operation.
module tb_shift_left_sequential;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    int total = 0;
    int bad   = 0;

    localparam int LATENCY = 5;
    localparam int BOUND   = 20;

    typedef struct {
        logic [31:0] din;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    shift_left_sequential dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, actual, expected);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid after an accept edge; returns cycles taken and
    // whether in_ready stayed low for the whole wait.
    task automatic wait_result(output int lat, output logic ready_seen);
        lat = 0;
        ready_seen = 1'b0;
        while (!out_valid && lat < BOUND) begin
            if (in_ready) ready_seen = 1'b1;
            tick();
            lat++;
        end
    endtask

    // Accept one operand, wait for the result, check it, and hand it off.
    task automatic run_op(input string name, input logic [31:0] din,
                          input logic [4:0] amt, input logic [31:0] exp);
        int   lat;
        logic ready_seen;
        check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in        = din;
        shamt     = amt;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_result(lat, ready_seen);
        check({name, " latency"}, 32'(lat), 32'(LATENCY));
        check({name, " in_ready low while busy"}, 32'(ready_seen), 32'd0);
        check({name, " out"}, out, exp);
        tick();
        check({name, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int   lat;
        logic ready_seen;
        logic saw_valid;

        vecs[0] = '{32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1] = '{32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[2] = '{32'h1234_5678, 5'd8,  32'h3456_7800};
        vecs[3] = '{32'h0000_0001, 5'd5,  32'h0000_0020};
        vecs[4] = '{32'hA5A5_A5A5, 5'd1,  32'h4B4B_4B4A};
        vecs[5] = '{32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000};
        vecs[6] = '{32'h8000_0001, 5'd31, 32'h8000_0000};
        vecs[7] = '{32'h0000_F00F, 5'd7,  32'h0078_0780};
        vecs[8] = '{32'h1234_5678, 5'd21, 32'hCF00_0000};

        // Reset from an arbitrary input state, with in_valid asserted
        // alongside rst so reset must win.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in        = $urandom();
        shamt     = 5'($urandom_range(0, 31));
        out_ready = 1'($urandom_range(0, 1));
        tick();
        tick();
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("reset out", out, 32'h0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        tick();
        check("idle stays idle", 32'(in_ready), 32'd1);

        // Table of single operations.
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].din, vecs[i].amt, vecs[i].exp);
        end

        // Backpressure: result must hold while a new operand is offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in        = 32'hFFFF_FFFF;
        shamt     = 5'd4;
        tick();
        in_valid = 1'b0;
        wait_result(lat, ready_seen);
        check("bp latency", 32'(lat), 32'(LATENCY));
        check("bp out", out, 32'hFFFF_FFF0);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in       = 32'h0000_00FF;
            shamt    = 5'd0;
            tick();
            check($sformatf("bp hold out c%0d", c), out, 32'hFFFF_FFF0);
            check($sformatf("bp hold valid c%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("bp hold in_ready c%0d", c), 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);
        check("bp idle holds out", out, 32'hFFFF_FFF0);

        // Back-to-back with out_ready held high; second operand is offered
        // throughout and must only be taken on the edge after the handshake.
        in_valid = 1'b1;
        in       = 32'h1234_5678;
        shamt    = 5'd8;
        tick();
        in    = 32'h0000_0001;
        shamt = 5'd5;
        wait_result(lat, ready_seen);
        check("b2b first latency", 32'(lat), 32'(LATENCY));
        check("b2b first out", out, 32'h3456_7800);
        tick();
        check("b2b handshake in_ready", 32'(in_ready), 32'd1);
        check("b2b handshake out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("b2b second accepted", 32'(in_ready), 32'd0);
        wait_result(lat, ready_seen);
        check("b2b second latency", 32'(lat), 32'(LATENCY));
        check("b2b second out", out, 32'h0000_0020);
        tick();

        // Reset asynchronously during the third shift cycle.
        in_valid = 1'b1;
        in       = 32'h0000_00F0;
        shamt    = 5'd3;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("midrst partial acc", out, 32'h0000_0780);
        #2;
        rst = 1'b1;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst out", out, 32'h0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        check("midrst no late result", 32'(saw_valid), 32'd0);
        check("midrst still idle", 32'(in_ready), 32'd1);

        // Reset wins over in_valid at the same edge.
        rst      = 1'b1;
        in_valid = 1'b1;
        in       = 32'hFFFF_FFFF;
        shamt    = 5'd1;
        tick();
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        check("rst beats in_valid ready", 32'(in_ready), 32'd1);
        check("rst beats in_valid out", out, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_left_sequential
